// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
// Size codes, FSM states, request bundle and lane helpers.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
  localparam logic [31:0] HALF_MASK = 32'h0000_ffff;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RMW,
    S_WRITE
  } lsu_state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Size 11 behaves as a word access.
  function automatic logic is_word(
    input logic [1:0] size
  );
    return size[1];
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return ((size == SZ_HALF) && off[0]) ||
           (is_word(size) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// lsu_lane_mux: byte/half lane extract with sign/zero
// extension, and lane merge for read-modify-write stores.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] ext,
  output logic [31:0] merged
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  b;
  logic [15:0] h;

  assign bsh = {off, 3'b000};
  assign hsh = {off[1], 4'b0000};
  assign b   = 8'(rdata >> bsh);
  assign h   = 16'(rdata >> hsh);

  // Extract the addressed lane and splice the store lane.
  always_comb begin
    ext    = rdata;
    merged = wdata;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        ext    = {{24{b[7] & ~uns}}, b};
        merged = (rdata & ~(BYTE_MASK << bsh)) |
                 ({24'b0, wdata[7:0]} << bsh);
      end
      (size == SZ_HALF): begin
        ext    = {{16{h[15] & ~uns}}, h};
        merged = (rdata & ~(HALF_MASK << hsh)) |
                 ({16'b0, wdata[15:0]} << hsh);
      end
      default: begin
        ext    = rdata;
        merged = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage LSU, sub-word stores via RMW.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned half/word.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_done,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misalign,
  output logic        dm_MemRead,
  output logic        dm_MemWrite,
  output logic [31:0] dm_Address,
  output logic [31:0] dm_WriteData,
  input  logic [31:0] dm_ReadData
);

  lsu_state_e  state;
  lsu_req_t    req_q;
  logic [31:0] merge_q;
  logic [31:0] ext;
  logic [31:0] merged;
  logic        mis_q;
  logic        accept;
  logic        reject;

`ifdef LSU_MISALIGN_TRAP_EN
  assign reject = misaligned(req_size, req_addr[1:0]);
`else
  assign reject = 1'b0;
`endif

  assign req_ready    = (state == S_IDLE);
  assign accept       = req_valid & req_ready;
  assign rsp_misalign = mis_q;

  assign dm_MemRead   = (state == S_LOAD) ||
                        (state == S_RMW);
  assign dm_MemWrite  = (state == S_WRITE) && req_q.write;
  assign dm_WriteData = dm_MemWrite ? merge_q : '0;
  assign dm_Address   = req_ready ? '0 :
                        {req_q.addr[31:2], 2'b00};

  lsu_lane_mux u_lane (
    .rdata  (dm_ReadData),
    .off    (req_q.addr[1:0]),
    .size   (req_q.size),
    .uns    (req_q.uns),
    .wdata  (req_q.wdata),
    .ext    (ext),
    .merged (merged)
  );

  // Request FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_q     <= '0;
      merge_q   <= '0;
      rsp_done  <= 1'b0;
      rsp_rdata <= '0;
      mis_q     <= 1'b0;
    end else begin
      rsp_done <= 1'b0;
      mis_q    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept && !reject) begin
            req_q <= '{write: req_write,
                       size:  req_size,
                       uns:   req_unsigned,
                       addr:  req_addr,
                       wdata: req_wdata};
            merge_q <= req_wdata;
            state   <= !req_write ? S_LOAD :
                       is_word(req_size) ? S_WRITE :
                       S_RMW;
          end else if (accept) begin
            rsp_done <= 1'b1;
            mis_q    <= 1'b1;
          end
        end
        S_LOAD: begin
          rsp_rdata <= ext;
          rsp_done  <= 1'b1;
          state     <= S_IDLE;
        end
        S_RMW: begin
          merge_q <= merged;
          state   <= S_WRITE;
        end
        S_WRITE: begin
          rsp_done <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed + random checks against a
// byte-array memory model; bench owns the data memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_done;
  logic [31:0] rsp_rdata;
  logic        rsp_misalign;
  logic        dm_MemRead;
  logic        dm_MemWrite;
  logic [31:0] dm_Address;
  logic [31:0] dm_WriteData;
  logic [31:0] dm_ReadData;

  logic [31:0] mem [0:63];
  logic [7:0]  rb  [0:255];
  logic [31:0] exp_rdata;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dm_ReadData = mem[dm_Address[7:2]];

  always @(posedge clk)
    if (dm_MemWrite) mem[dm_Address[7:2]] <= dm_WriteData;

  load_store_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_done     (rsp_done),
    .rsp_rdata    (rsp_rdata),
    .rsp_misalign (rsp_misalign),
    .dm_MemRead   (dm_MemRead),
    .dm_MemWrite  (dm_MemWrite),
    .dm_Address   (dm_Address),
    .dm_WriteData (dm_WriteData),
    .dm_ReadData  (dm_ReadData)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    int w;
    w = a & ~3;
    return {rb[w+3], rb[w+2], rb[w+1], rb[w]};
  endfunction

  function automatic logic [31:0] ref_load(
    input logic [1:0] sz, input logic u, input int a);
    int v;
    int h;
    if (sz == 2'd0) begin
      v = int'(rb[a]);
      if (!u && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      h = a & ~1;
      v = int'(rb[h]) + int'(rb[h+1]) * 256;
      if (!u && v >= 32768) v = v - 65536;
    end else begin
      v = int'(ref_word(a));
    end
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [1:0] sz,
                           input int a,
                           input logic [31:0] d);
    int base;
    if (sz == 2'd0) begin
      rb[a] = d[7:0];
    end else if (sz == 2'd1) begin
      base = a & ~1;
      rb[base]   = d[7:0];
      rb[base+1] = d[15:8];
    end else begin
      base = a & ~3;
      for (int k = 0; k < 4; k++) rb[base+k] = d[8*k +: 8];
    end
  endtask

  task automatic set_word(input int a, input logic [31:0] d);
    mem[a >> 2] = d;
    ref_store(2'd2, a, d);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_done"}, 32'(rsp_done), 32'd0);
    chk({tag, "_mis"}, 32'(rsp_misalign), 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_mrd"}, 32'(dm_MemRead), 32'd0);
    chk({tag, "_mwr"}, 32'(dm_MemWrite), 32'd0);
    chk({tag, "_addr"}, dm_Address, 32'd0);
    chk({tag, "_wd"}, dm_WriteData, 32'd0);
  endtask

  task automatic issue(input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] addr,
                       input logic [31:0] d);
    int lat  = 0;
    int rlow = 0;
    int nwr  = 0;
    int nrd  = 0;
    int a;
    int exp_lat;
    a = int'(addr[7:0]);
    exp_lat = (w && !sz[1]) ? 3 : 2;
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = addr;
    req_wdata    = d;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_size     = 2'($urandom_range(0, 3));
    chk("dm_addr", dm_Address, {addr[31:2], 2'b00});
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (!req_ready) rlow++;
      if (dm_MemWrite) nwr++;
      if (dm_MemRead) nrd++;
      if (rsp_done) break;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("ready_low", 32'(rlow), 32'(exp_lat - 1));
    chk("writes", 32'(nwr), w ? 32'd1 : 32'd0);
    chk("reads", 32'(nrd),
        (!w || !sz[1]) ? 32'd1 : 32'd0);
    if (!w) exp_rdata = ref_load(sz, u, a);
    else ref_store(sz, a, d);
    chk("rdata", rsp_rdata, exp_rdata);
    chk("memword", mem[a >> 2], ref_word(a));
  endtask

  initial begin
    logic [1:0]  rsz;
    logic [31:0] ra;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    exp_rdata    = '0;
    for (int i = 0; i < 64; i++) set_word(i * 4, $urandom);
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;

    issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hdeadbeef);
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    chk("plan_lw", rsp_rdata, 32'hdeadbeef);

    set_word(32'h20, 32'h11223344);
    issue(1'b1, SZ_BYTE, 1'b0, 32'h22, 32'h000000aa);
    chk("plan_sb", mem[8], 32'h11aa3344);

    set_word(32'h30, 32'h80ff7f01);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h33, 32'h0);
    chk("plan_lb", rsp_rdata, 32'hffffff80);
    issue(1'b0, SZ_BYTE, 1'b1, 32'h33, 32'h0);
    chk("plan_lbu", rsp_rdata, 32'h00000080);
    issue(1'b0, SZ_HALF, 1'b0, 32'h32, 32'h0);
    chk("plan_lh", rsp_rdata, 32'hffff80ff);
    issue(1'b0, SZ_HALF, 1'b1, 32'h30, 32'h0);
    chk("plan_lhu", rsp_rdata, 32'h00007f01);

    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = 1'b0;
    req_size     = SZ_WORD;
    req_unsigned = 1'b0;
    req_addr     = 32'h30;
    @(posedge clk);
    #1;
    req_size     = SZ_BYTE;
    req_unsigned = 1'b1;
    req_addr     = 32'h33;
    @(negedge clk);
    chk("b2b_busy", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("b2b_done1", 32'(rsp_done), 32'd1);
    chk("b2b_ready1", 32'(req_ready), 32'd1);
    exp_rdata = ref_load(SZ_WORD, 1'b0, 32'h30);
    chk("b2b_rdata1", rsp_rdata, exp_rdata);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_accepted", 32'(req_ready), 32'd0);
    chk("b2b_nodone", 32'(rsp_done), 32'd0);
    @(negedge clk);
    chk("b2b_done2", 32'(rsp_done), 32'd1);
    exp_rdata = ref_load(SZ_BYTE, 1'b1, 32'h33);
    chk("b2b_rdata2", rsp_rdata, 32'h00000080);

    for (int n = 0; n < 40; n++) begin
      rsz = 2'($urandom_range(0, 3));
      ra  = 32'($urandom_range(0, 255));
      if (rsz == 2'd1) ra[0] = 1'b0;
      if (rsz[1]) ra[1:0] = 2'b00;
      issue(1'($urandom_range(0, 1)), rsz,
            1'($urandom_range(0, 1)), ra, $urandom);
    end

    set_word(32'h40, 32'h12345678);
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = 1'b1;
    req_size     = SZ_HALF;
    req_addr     = 32'h40;
    req_wdata    = 32'h0000beef;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rmw_state", 32'(dm_MemRead), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    exp_rdata = '0;
    chk_reset("midrmw");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrmw_mem", mem[16], 32'h12345678);
    chk("midrmw_rdata", rsp_rdata, 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = SZ_WORD;
    req_addr  = 32'h41;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mis_noread", 32'(dm_MemRead), 32'd0);
    chk("mis_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("mis_done", 32'(rsp_done), 32'd1);
    chk("mis_flag", 32'(rsp_misalign), 32'd1);
    chk("mis_rdata", rsp_rdata, exp_rdata);
    @(negedge clk);
    chk("mis_pulse", 32'(rsp_misalign), 32'd0);
`else
    issue(1'b0, SZ_WORD, 1'b0, 32'h41, 32'h0);
    chk("unaligned_lw", rsp_rdata, 32'h12345678);
    chk("no_mis", 32'(rsp_misalign), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
